// File: rtl/gs_lsu.sv
// gs_lsu: single-outstanding load-store unit between EX and a req/gnt/rvalid data bus.
// Build option: define GS_LSU_MISALIGN_TRAP_EN to trap misaligned/illegal accesses instead of forcing alignment.
module gs_lsu #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_req_i,
  input  logic                 ex_we_i,
  input  logic [1:0]           ex_size_i,
  input  logic                 ex_unsigned_i,
  input  logic [ADDR_SIZE-1:0] ex_addr_i,
  input  logic [WORD_SIZE-1:0] ex_wdata_i,
  input  logic                 flush_i,
  output logic                 lsu_ready_o,
  output logic                 lsu_busy_o,
  output logic                 lsu_rvalid_o,
  output logic [WORD_SIZE-1:0] lsu_rdata_o,
  output logic                 lsu_err_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [ADDR_SIZE-1:0] data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [WORD_SIZE-1:0] data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic [WORD_SIZE-1:0] data_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  state_e state_q, state_d;

  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [1:0]           off_q, off_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 kill_q, kill_d;

  logic                 accept;
  logic                 misalign;
  logic [1:0]           off_eff;
  logic [1:0]           size_eff;
  logic [3:0]           be_new;
  logic [WORD_SIZE-1:0] wdata_new;
  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] load_ext;

  // Access decode: either flag misalignment or fold the offset/size into a legal access.
  always_comb begin
    off_eff  = ex_addr_i[1:0];
    size_eff = ex_size_i;
`ifdef GS_LSU_MISALIGN_TRAP_EN
    unique case (ex_size_i)
      2'b01:   misalign = ex_addr_i[0];
      2'b10:   misalign = |ex_addr_i[1:0];
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
    if (ex_size_i == 2'b01) begin
      off_eff[0] = 1'b0;
    end else if (ex_size_i[1]) begin
      off_eff  = '0;
      size_eff = 2'b10;
    end
`endif
    unique case (size_eff)
      2'b00: begin
        be_new    = 4'b0001 << off_eff;
        wdata_new = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << off_eff;
        wdata_new = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = ex_wdata_i;
      end
    endcase
  end

  always_comb begin
    shifted = data_rdata_i >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && !misalign) state_d = ST_REQ;
      ST_REQ: begin
        if (flush_i)         state_d = ST_IDLE;
        else if (data_gnt_i) state_d = ST_RESP;
      end
      ST_RESP: if (data_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lsu_ready_o = (state_q == ST_IDLE) && !flush_i;
    data_req_o  = (state_q == ST_REQ);
  end

  assign accept = ex_req_i && lsu_ready_o;

  // A flush seen while waiting for the response is remembered so the late rvalid is swallowed.
  always_comb begin
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    kill_d   = kill_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    if (accept) begin
      if (misalign) begin
        err_d = 1'b1;
      end else begin
        we_d    = ex_we_i;
        size_d  = size_eff;
        uns_d   = ex_unsigned_i;
        off_d   = off_eff;
        addr_d  = {ex_addr_i[ADDR_SIZE-1:2], 2'b00};
        be_d    = be_new;
        wdata_d = wdata_new;
        kill_d  = 1'b0;
      end
    end
    if (state_q == ST_RESP) begin
      if (flush_i) kill_d = 1'b1;
      if (data_rvalid_i) begin
        kill_d = 1'b0;
        if (!(kill_q || flush_i)) begin
          rvalid_d = 1'b1;
          rdata_d  = we_q ? '0 : load_ext;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      off_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      kill_q   <= kill_d;
    end
  end

  assign lsu_busy_o   = busy_q;
  assign lsu_rvalid_o = rvalid_q;
  assign lsu_rdata_o  = rdata_q;
  assign lsu_err_o    = err_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule
